// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision multiplier datapath:
// status bit positions, rounding modes and the result record.
package fp_pkg;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  typedef enum logic [2:0] {
    IEEE_near,
    IEEE_zero,
    IEEE_pinf,
    IEEE_ninf,
    away_zero
  } rnd_mode_t;

  // Status sits above the result word so {status, z} reads naturally.
  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] z;
  } fp_res_t;

  function automatic fp_res_t pack_res(input logic [31:0] z, input logic [7:0] status);
    fp_res_t r;
    r.status = status;
    r.z      = z;
    return r;
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Result storage FIFO: DEPTH entries of fp_res_t, combinational head read,
// push while full is accepted only together with a pop.
module fp_res_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  fp_res_t wdata,
  output fp_res_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fp_res_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr_reg];

  // Storage is reset so the head reads zero straight out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en) begin
      count_next = count_reg + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/fp_mult_result_buf.sv
// Multiplier result buffer: FIFO, issue-credit counter, sticky flags and error.
// Optional same-cycle bypass when empty is enabled by defining FP_RES_BYPASS_EN.
module fp_mult_result_buf
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_fire,
  output logic        issue_ok,
  input  logic        in_valid,
  input  logic [31:0] z_in,
  input  logic [7:0]  status_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z_out,
  output logic [7:0]  status_out,
  output logic [7:0]  flags_acc,
  input  logic        flags_clr,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fp_res_t       fifo_head;
  fp_res_t       out_res;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          pop;
  logic          overflow;
  logic          cr_inc;
  logic          cr_dec;
  logic [CW-1:0] cr_reg;
  logic [CW-1:0] cr_next;
  logic [7:0]    flags_reg;
  logic [7:0]    flags_next;
  logic          err_reg;

  fp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pack_res(z_in, status_in)),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FP_RES_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && in_valid;
  assign out_valid = !fifo_empty || in_valid;
  assign out_res   = bypass ? pack_res(z_in, status_in) : fifo_head;
  // A bypassed result taken this cycle never lands in storage.
  assign fifo_push = in_valid && !(bypass && out_ready);
`else
  assign out_valid = !fifo_empty;
  assign out_res   = fifo_head;
  assign fifo_push = in_valid;
`endif

  assign z_out      = out_res.z;
  assign status_out = out_res.status;
  assign pop        = out_valid && out_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign overflow   = in_valid && fifo_full && !fifo_pop;

  assign issue_ok = (cr_reg != CW'(DEPTH));
  assign cr_inc   = issue_fire && issue_ok;
  // Floor at zero so a protocol-violating upstream cannot wrap the counter.
  assign cr_dec   = pop && (cr_reg != '0);

  always_comb begin
    cr_next = cr_reg;
    if (cr_inc && !cr_dec) begin
      cr_next = cr_reg + CW'(1);
    end else if (cr_dec && !cr_inc) begin
      cr_next = cr_reg - CW'(1);
    end
  end

  always_comb begin
    flags_next = flags_clr ? 8'h00 : flags_reg;
    if (in_valid) flags_next = flags_next | status_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_reg    <= '0;
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      cr_reg    <= cr_next;
      flags_reg <= flags_next;
      if (overflow || (issue_fire && !issue_ok)) err_reg <= 1'b1;
    end
  end

  assign flags_acc = flags_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_fp_mult_result_buf.sv
// Table-driven bench for fp_mult_result_buf with a result scoreboard queue;
// expectations follow FP_RES_BYPASS_EN when the bench is built with it.
module tb_fp_mult_result_buf;

  localparam int DEPTH = 4;
`ifdef FP_RES_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_fire;
  logic        issue_ok;
  logic        in_valid;
  logic [31:0] z_in;
  logic [7:0]  status_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z_out;
  logic [7:0]  status_out;
  logic [7:0]  flags_acc;
  logic        flags_clr;
  logic        err;

  fp_mult_result_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_fire (issue_fire),
    .issue_ok   (issue_ok),
    .in_valid   (in_valid),
    .z_in       (z_in),
    .status_in  (status_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z_out      (z_out),
    .status_out (status_out),
    .flags_acc  (flags_acc),
    .flags_clr  (flags_clr),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic        iv;
    logic [31:0] z;
    logic [7:0]  st;
    logic        ordy;
    logic        clr;
    logic        e_ok;
    logic        e_v;
    logic [31:0] e_z;
    logic [7:0]  e_flags;
    logic        e_err;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [39:0] sb_q[$];
  vec_t        tbl[21];

  function automatic vec_t mk(input logic fire, input logic iv, input logic [31:0] z,
                              input logic [7:0] st, input logic ordy, input logic clr,
                              input logic e_ok, input logic e_v, input logic [31:0] e_z,
                              input logic [7:0] e_flags, input logic e_err);
    vec_t v;
    v.fire = fire; v.iv = iv; v.z = z; v.st = st; v.ordy = ordy; v.clr = clr;
    v.e_ok = e_ok; v.e_v = e_v; v.e_z = e_z; v.e_flags = e_flags; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_fire = 1'b0; in_valid = 1'b0; z_in = '0; status_in = '0;
    out_ready = 1'b0; flags_clr = 1'b0;
  endtask

  // Called just after a rising edge; leaves inputs idle just after the next one.
  task automatic apply(input string tag, input vec_t v);
    logic exp_v;
    logic consumed;
    issue_fire = v.fire; in_valid = v.iv; z_in = v.z; status_in = v.st;
    out_ready = v.ordy; flags_clr = v.clr;
    #1;
    exp_v = (sb_q.size() != 0) || (BYP && v.iv);
    chk({tag, " pre_valid"}, 40'(out_valid), 40'(exp_v));
    consumed = 1'b0;
    if (exp_v && v.ordy) begin
      if (sb_q.size() != 0) begin
        chk({tag, " head"}, {status_out, z_out}, sb_q[0]);
        sb_q.delete(0);
      end else begin
        chk({tag, " bypass"}, {status_out, z_out}, {v.st, v.z});
        consumed = 1'b1;
      end
    end
    if (v.iv && !consumed && sb_q.size() < DEPTH) sb_q.push_back({v.st, v.z});
    @(posedge clk);
    #1;
    idle();
    #1;
    chk({tag, " issue_ok"}, 40'(issue_ok), 40'(v.e_ok));
    chk({tag, " out_valid"}, 40'(out_valid), 40'(v.e_v));
    if (v.e_v) chk({tag, " z_out"}, 40'(z_out), 40'(v.e_z));
    chk({tag, " flags_acc"}, 40'(flags_acc), 40'(v.e_flags));
    chk({tag, " err"}, 40'(err), 40'(v.e_err));
    $display("%s: fire=%0b iv=%0b z=%h st=%h rdy=%0b clr=%0b -> ok=%0b v=%0b z_out=%h flags=%h err=%0b",
             tag, v.fire, v.iv, v.z, v.st, v.ordy, v.clr, issue_ok, out_valid, z_out, flags_acc, err);
  endtask

  initial begin
    //             fire iv  z             st     rdy  clr  ok   v    e_z           flags  err
    tbl[0]  = mk(1, 0, 32'h0,        8'h00, 0, 0, 1, 0, 32'h0,        8'h00, 0);
    tbl[1]  = mk(1, 0, 32'h0,        8'h00, 0, 0, 1, 0, 32'h0,        8'h00, 0);
    tbl[2]  = mk(1, 0, 32'h0,        8'h00, 0, 0, 1, 0, 32'h0,        8'h00, 0);
    tbl[3]  = mk(1, 0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        8'h00, 0);
    tbl[4]  = mk(0, 1, 32'h40C00000, 8'h00, 0, 0, 0, 1, 32'h40C00000, 8'h00, 0);
    tbl[5]  = mk(0, 1, 32'h3F800000, 8'h20, 0, 0, 0, 1, 32'h40C00000, 8'h20, 0);
    tbl[6]  = mk(0, 1, 32'h40000000, 8'h10, 0, 0, 0, 1, 32'h40C00000, 8'h30, 0);
    tbl[7]  = mk(0, 1, 32'h40400000, 8'h00, 0, 0, 0, 1, 32'h40C00000, 8'h30, 0);
    tbl[8]  = mk(0, 1, 32'h3F800000, 8'h00, 0, 0, 0, 1, 32'h40C00000, 8'h30, 1);
    tbl[9]  = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h3F800000, 8'h30, 1);
    tbl[10] = mk(1, 1, 32'h40800000, 8'h00, 0, 0, 0, 1, 32'h3F800000, 8'h30, 1);
    tbl[11] = mk(0, 1, 32'h40A00000, 8'h00, 1, 0, 1, 1, 32'h40000000, 8'h30, 1);
    tbl[12] = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h40400000, 8'h30, 1);
    tbl[13] = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h40800000, 8'h30, 1);
    tbl[14] = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h40A00000, 8'h30, 1);
    tbl[15] = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 0, 32'h0,        8'h30, 1);
    tbl[16] = mk(0, 0, 32'h0,        8'h00, 0, 1, 1, 0, 32'h0,        8'h00, 1);
    tbl[17] = mk(1, 1, 32'h3F800000, 8'h20, 0, 0, 1, 1, 32'h3F800000, 8'h20, 1);
    tbl[18] = mk(1, 1, 32'h40000000, 8'h10, 1, 0, 1, 1, 32'h40000000, 8'h30, 1);
    tbl[19] = mk(1, 1, 32'h40400000, 8'h04, 1, 1, 1, 1, 32'h40400000, 8'h04, 1);
    tbl[20] = mk(0, 0, 32'h0,        8'h00, 1, 0, 1, 0, 32'h0,        8'h04, 1);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset issue_ok", 40'(issue_ok), 40'd1);
    chk("reset out_valid", 40'(out_valid), 40'd0);
    chk("reset head", {status_out, z_out}, 40'd0);
    chk("reset flags_acc", 40'(flags_acc), 40'd0);
    chk("reset err", 40'(err), 40'd0);

    for (int i = 0; i < 21; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Result arriving at an empty buffer with the consumer ready.
    apply("empty_rdy", mk(1, 1, 32'h40E00000, 8'h00, 1, 0, 1, !BYP, 32'h40E00000, 8'h04, 1));
    apply("empty_drain", mk(0, 0, 32'h0, 8'h00, 1, 0, 1, 0, 32'h0, 8'h04, 1));

    // Asynchronous reset mid-operation discards buffered data and clears err.
    apply("pre_reset", mk(1, 1, 32'h41100000, 8'h20, 0, 0, 1, 1, 32'h41100000, 8'h24, 1));
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("async issue_ok", 40'(issue_ok), 40'd1);
    chk("async out_valid", 40'(out_valid), 40'd0);
    chk("async head", {status_out, z_out}, 40'd0);
    chk("async flags_acc", 40'(flags_acc), 40'd0);
    chk("async err", 40'(err), 40'd0);
    $display("async_reset: ok=%0b v=%0b flags=%h err=%0b", issue_ok, out_valid, flags_acc, err);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("post_reset", mk(1, 1, 32'h41000000, 8'h01, 0, 0, 1, 1, 32'h41000000, 8'h01, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
